// File: rtl/uart_mmio_ctrl_pkg.sv
// Shared types and register map for the UART MMIO controller.
package uart_mmio_ctrl_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, WAIT_BUSY, WAIT_DONE} uart_ctrl_state_t;

    localparam logic [3:0] UART_TXDATA_OFS = 4'h0;
    localparam logic [3:0] UART_RXDATA_OFS = 4'h4;
    localparam logic [3:0] UART_STATUS_OFS = 4'h8;
    localparam logic [3:0] UART_CTRL_OFS   = 4'hC;

    localparam int ST_FIFO_EMPTY = 0;
    localparam int ST_FIFO_FULL  = 1;
    localparam int ST_RX_FULL    = 2;
    localparam int ST_OVERRUN    = 3;
    localparam int ST_TX_OVF     = 4;

    localparam int CTRL_RX_IRQ_EN = 0;
    localparam int CTRL_TX_IRQ_EN = 1;

    // Cycles to wait for tx_busy before assuming the engine finished instantly.
    localparam int BUSY_TIMEOUT = 4;

endpackage

// File: rtl/uart_mmio_ctrl_tx_fifo.sv
// Byte FIFO feeding the TX scheduler; head is visible combinationally.
module uart_tx_fifo
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       push,
    input  logic       pop,
    input  logic [7:0] din,
    output logic [7:0] head,
    output logic       full,
    output logic       empty
);
    localparam int AW = $clog2(TX_DEPTH);

    logic [AW:0] wr_ptr_q, wr_ptr_d;
    logic [AW:0] rd_ptr_q, rd_ptr_d;
    logic [7:0]  mem_q [TX_DEPTH];
    logic        push_ok, pop_ok;

    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign pop_ok  = pop && !empty;
    // A pop on the same edge frees the slot, so a push while full still lands.
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem_q[rd_ptr_q[AW-1:0]];

    always_comb begin
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop_ok};
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem_q[wr_ptr_q[AW-1:0]] <= din;
    end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// CPU-facing UART register block: TX byte FIFO + launch scheduler, single RX holding register, IRQ.
module uart_mmio_ctrl
    import uart_mmio_ctrl_pkg::*;
#(
    parameter int TX_DEPTH = 4,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              sel,
    input  logic              we,
    input  logic              re,
    input  logic [3:0]        addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic [7:0]        tx_data,
    output logic              tx_start,
    input  logic              tx_busy,
    input  logic [7:0]        rx_data,
    input  logic              rx_valid,
    output logic              irq
);
    uart_ctrl_state_t state_q, state_d;
    logic [1:0] wait_cnt_q, wait_cnt_d;
    logic [7:0] tx_data_q, tx_data_d;
    logic       tx_start_q, tx_start_d;
    logic [7:0] rx_hold_q, rx_hold_d;
    logic       rx_full_q, rx_full_d;
    logic       overrun_q, overrun_d;
    logic       tx_ovf_q, tx_ovf_d;
    logic [1:0] ctrl_q, ctrl_d;
    logic       irq_q, irq_d;

    logic       wr_tx, wr_st, wr_ctrl, rd_rx;
    logic       fifo_pop, fifo_full, fifo_empty;
    logic [7:0] fifo_head;
    logic       unused_wdata;

    assign wr_tx   = sel && we && (addr == UART_TXDATA_OFS);
    assign wr_st   = sel && we && (addr == UART_STATUS_OFS);
    assign wr_ctrl = sel && we && (addr == UART_CTRL_OFS);
    assign rd_rx   = sel && re && (addr == UART_RXDATA_OFS);
    assign fifo_pop = (state_q == LOAD);
    assign unused_wdata = ^wdata[DATA_W-1:8];

    uart_tx_fifo #(.TX_DEPTH(TX_DEPTH)) u_tx_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (wr_tx),
        .pop   (fifo_pop),
        .din   (wdata[7:0]),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        ctrl_d   = wr_ctrl ? wdata[1:0] : ctrl_q;
        tx_ovf_d = tx_ovf_q;
        if (wr_st && wdata[ST_TX_OVF]) tx_ovf_d = 1'b0;
        if (wr_tx && fifo_full && !fifo_pop) tx_ovf_d = 1'b1;

        rx_hold_d = rx_hold_q;
        rx_full_d = rx_full_q;
        overrun_d = overrun_q;
        if (wr_st && wdata[ST_OVERRUN]) overrun_d = 1'b0;
        // A byte arriving on the pop cycle replaces the one being read out.
        if (rx_valid) begin
            if (!rx_full_q || rd_rx) rx_hold_d = rx_data;
            else                     overrun_d = 1'b1;
            rx_full_d = 1'b1;
        end else if (rd_rx) begin
            rx_full_d = 1'b0;
        end

        irq_d = (ctrl_q[CTRL_RX_IRQ_EN] && rx_full_q) ||
                (ctrl_q[CTRL_TX_IRQ_EN] && fifo_empty && (state_q == IDLE) && !tx_busy);
    end

    always_comb begin
        state_d    = state_q;
        wait_cnt_d = wait_cnt_q;
        tx_data_d  = tx_data_q;
        tx_start_d = 1'b0;
        case (state_q)
            IDLE: if (!fifo_empty && !tx_busy) state_d = LOAD;
            LOAD: begin
                tx_data_d  = fifo_head;
                tx_start_d = 1'b1;
                wait_cnt_d = '0;
                state_d    = WAIT_BUSY;
            end
            WAIT_BUSY: begin
                if (tx_busy || (wait_cnt_q == 2'(BUSY_TIMEOUT - 1))) state_d = WAIT_DONE;
                else wait_cnt_d = wait_cnt_q + 2'd1;
            end
            WAIT_DONE: if (!tx_busy) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            wait_cnt_q <= '0;
            tx_data_q  <= '0;
            tx_start_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            tx_data_q  <= tx_data_d;
            tx_start_q <= tx_start_d;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_hold_q <= '0;
            rx_full_q <= 1'b0;
            overrun_q <= 1'b0;
            tx_ovf_q  <= 1'b0;
            ctrl_q    <= '0;
            irq_q     <= 1'b0;
        end else begin
            rx_hold_q <= rx_hold_d;
            rx_full_q <= rx_full_d;
            overrun_q <= overrun_d;
            tx_ovf_q  <= tx_ovf_d;
            ctrl_q    <= ctrl_d;
            irq_q     <= irq_d;
        end
    end

    always_comb begin
        rdata = '0;
        if (sel) begin
            case (addr)
                UART_RXDATA_OFS: rdata[7:0] = rx_hold_q;
                UART_STATUS_OFS: begin
                    rdata[ST_TX_OVF]     = tx_ovf_q;
                    rdata[ST_OVERRUN]    = overrun_q;
                    rdata[ST_RX_FULL]    = rx_full_q;
                    rdata[ST_FIFO_FULL]  = fifo_full;
                    rdata[ST_FIFO_EMPTY] = fifo_empty;
                end
                UART_CTRL_OFS: rdata[1:0] = ctrl_q;
                default: rdata = '0;
            endcase
        end
    end

    assign tx_data  = tx_data_q;
    assign tx_start = tx_start_q;
    assign irq      = irq_q;

endmodule

// File: tb/tb_uart_mmio_ctrl.sv
// Randomised scoreboard bench for uart_mmio_ctrl with a queue-based register/FIFO model.
module tb_uart_mmio_ctrl;
    localparam int TX_DEPTH = 4;
    localparam int DATA_W   = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b0;
    logic              sel = 1'b0, we = 1'b0, re = 1'b0;
    logic [3:0]        addr = '0;
    logic [DATA_W-1:0] wdata = '0;
    logic [DATA_W-1:0] rdata;
    logic [7:0]        tx_data;
    logic              tx_start;
    logic              tx_busy;
    logic [7:0]        rx_data = '0;
    logic              rx_valid = 1'b0;
    logic              irq;

    logic eng_busy = 1'b0, hold_busy = 1'b0;
    int   busy_len = 10;
    assign tx_busy = eng_busy | hold_busy;

    uart_mmio_ctrl #(.TX_DEPTH(TX_DEPTH), .DATA_W(DATA_W)) dut (
        .clk(clk), .rst(rst), .sel(sel), .we(we), .re(re), .addr(addr),
        .wdata(wdata), .rdata(rdata), .tx_data(tx_data), .tx_start(tx_start),
        .tx_busy(tx_busy), .rx_data(rx_data), .rx_valid(rx_valid), .irq(irq)
    );

    always #5 clk = ~clk;

    int checks = 0, errors = 0;

    // Reference model: pending TX bytes (also the scoreboard), RX holding state, flags.
    logic [7:0] m_fifo[$];
    logic       m_ovf = 0, m_ovr = 0, m_rxf = 0;
    logic [7:0] m_hold = '0;
    logic [1:0] m_ctrl = '0;

    function automatic logic [31:0] m_status();
        return {27'b0, m_ovf, m_ovr, m_rxf, m_fifo.size() == TX_DEPTH, m_fifo.size() == 0};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] e);
        checks++;
        if (act !== e) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, e, $time);
        end
    endtask

    // TX engine: busy for busy_len cycles after each launch, cleared by reset.
    initial begin
        forever begin
            @(posedge clk); #1;
            if (tx_start && busy_len > 0) begin
                eng_busy = 1'b1;
                for (int i = 0; i < busy_len && rst; i++) @(posedge clk);
                #1 eng_busy = 1'b0;
            end
        end
    end

    // Monitor: every launch must carry the oldest pending byte and last exactly one cycle.
    initial begin
        logic prev_start;
        logic [7:0] e;
        prev_start = 1'b0;
        forever begin
            @(posedge clk); #2;
            if (tx_start) begin
                chk("start_width", {31'b0, prev_start}, 32'h0);
                if (m_fifo.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL tx_unexpected actual=%h expected=none t=%0t", tx_data, $time);
                end else begin
                    e = m_fifo.pop_front();
                    chk("tx_byte", {24'b0, tx_data}, {24'b0, e});
                end
            end
            prev_start = tx_start;
        end
    end

    task automatic wr(input logic [3:0] a, input logic [31:0] d);
        @(negedge clk); sel = 1; we = 1; addr = a; wdata = d;
        @(negedge clk); sel = 0; we = 0;
        case (a)
            4'h0: if (m_fifo.size() < TX_DEPTH) m_fifo.push_back(d[7:0]); else m_ovf = 1;
            4'h8: begin if (d[4]) m_ovf = 0; if (d[3]) m_ovr = 0; end
            4'hC: m_ctrl = d[1:0];
            default: ;
        endcase
    endtask

    task automatic rd(input logic [3:0] a, input string name);
        logic [31:0] e;
        @(negedge clk); sel = 1; re = 1; addr = a;
        case (a)
            4'h4: e = {24'b0, m_hold};
            4'h8: e = m_status();
            4'hC: e = {30'b0, m_ctrl};
            default: e = '0;
        endcase
        #1 chk(name, rdata, e);
        @(negedge clk); sel = 0; re = 0;
        if (a == 4'h4) m_rxf = 0;
    endtask

    task automatic rx_inject(input logic [7:0] b);
        @(negedge clk); rx_valid = 1; rx_data = b;
        @(negedge clk); rx_valid = 0;
        if (!m_rxf) begin m_hold = b; m_rxf = 1; end
        else m_ovr = 1;
    endtask

    task automatic rx_and_read(input logic [7:0] b);
        @(negedge clk); sel = 1; re = 1; addr = 4'h4; rx_valid = 1; rx_data = b;
        #1 chk("rx_pop_same_cycle", rdata, {24'b0, m_hold});
        @(negedge clk); sel = 0; re = 0; rx_valid = 0;
        m_hold = b; m_rxf = 1;
    endtask

    // Only meaningful once the scheduler has settled.
    task automatic chk_irq(input string name);
        logic e;
        @(posedge clk); #1;
        e = (m_ctrl[0] & m_rxf) | (m_ctrl[1] & (m_fifo.size() == 0) & !tx_busy);
        chk(name, {31'b0, irq}, {31'b0, e});
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((m_fifo.size() != 0 || tx_busy) && n < 400) begin
            @(negedge clk); n++;
        end
        if (n >= 400) begin
            checks++; errors++;
            $display("FAIL drain_timeout actual=%0d pending expected=0", m_fifo.size());
        end
        repeat (8) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        rst = 1;

        rd(4'h8, "reset_status");
        rd(4'hC, "reset_ctrl");
        chk("reset_irq", {31'b0, irq}, 32'h0);
        chk("reset_tx_start", {31'b0, tx_start}, 32'h0);

        // Single byte: launch latency, pulse width, FIFO empty, back to IDLE.
        busy_len = 10;
        wr(4'h0, 32'h41);
        @(posedge clk); #1 chk("latency_edge1", {31'b0, tx_start}, 32'h0);
        @(posedge clk); #1 chk("latency_edge2", {31'b0, tx_start}, 32'h1);
        chk("latency_data", {24'b0, tx_data}, 32'h41);
        rd(4'h8, "status_after_load");
        wait_drain();
        wr(4'hC, 32'h2);
        chk_irq("tx_idle_irq");

        // Overfill with engine held busy.
        hold_busy = 1;
        for (int i = 0; i < 4; i++) wr(4'h0, 32'h10 + i);
        rd(4'h8, "status_full");
        wr(4'h0, 32'h14);
        rd(4'h8, "status_tx_ovf");
        hold_busy = 0;
        wait_drain();
        wr(4'h8, 32'h10);
        rd(4'h8, "status_ovf_clear");
        rd(4'h0, "txdata_reads_zero");
        rd(4'h2, "unmapped_read");
        @(negedge clk); sel = 0; re = 1; addr = 4'h8;
        #1 chk("unselected_read", rdata, 32'h0);
        re = 0;

        // RX holding register, overrun, simultaneous pop and arrival.
        rx_inject(8'h5A);
        rd(4'h8, "rx_full");
        rx_inject(8'hA5);
        rd(4'h8, "rx_overrun");
        rd(4'h4, "rx_keeps_old");
        rd(4'h8, "rx_cleared");
        wr(4'h8, 32'h08);
        wr(4'h4, 32'hFF);
        rx_inject(8'h22);
        rx_and_read(8'h33);
        rd(4'h8, "rx_same_cycle_status");
        rd(4'h4, "rx_same_cycle_data");

        // RX interrupt with one-cycle lag.
        wr(4'hC, 32'h1);
        rx_inject(8'h99);
        chk("irq_lag", {31'b0, irq}, 32'h0);
        chk_irq("rx_irq_set");
        rd(4'h4, "rx_irq_data");
        chk_irq("rx_irq_clear");

        // Randomised TX bursts, including the instant-engine timeout path.
        for (int it = 0; it < 12; it++) begin
            busy_len = $urandom_range(0, 6);
            hold_busy = 1;
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) wr(4'h0, $urandom);
            rd(4'h8, "rand_tx_status_held");
            if ($urandom_range(0, 1) == 1) wr(4'hC, $urandom);
            hold_busy = 0;
            wait_drain();
            rd(4'h8, "rand_tx_status_drained");
            chk_irq("rand_tx_irq");
            wr(4'h8, $urandom);
            rd(4'h8, "rand_w1c");
        end

        // Randomised RX traffic.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 4))
                0, 1: rx_inject(8'($urandom));
                2: rd(4'h4, "rand_rx_data");
                3: rx_and_read(8'($urandom));
                default: begin
                    rd(4'h8, "rand_rx_status");
                    if ($urandom_range(0, 1) == 1) wr(4'h8, $urandom);
                end
            endcase
        end

        // Reset while the scheduler waits for the engine to finish.
        wr(4'hC, 32'h1);
        if (!m_rxf) rx_inject(8'h5C);
        busy_len = 10;
        wr(4'h0, 32'h77);
        repeat (5) @(negedge clk);
        #2 rst = 0;
        #1;
        chk("midreset_tx_start", {31'b0, tx_start}, 32'h0);
        chk("midreset_tx_data", {24'b0, tx_data}, 32'h0);
        chk("midreset_irq", {31'b0, irq}, 32'h0);
        m_fifo.delete(); m_ovf = 0; m_ovr = 0; m_rxf = 0; m_hold = '0; m_ctrl = '0;
        sel = 1; addr = 4'h8;
        #1 chk("midreset_status", rdata, m_status());
        addr = 4'hC;
        #1 chk("midreset_ctrl", rdata, 32'h0);
        sel = 0;
        @(negedge clk); rst = 1;
        repeat (4) @(negedge clk);
        rd(4'h8, "post_reset_status");
        rd(4'h4, "post_reset_rxdata");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
